// File: rtl/fp2i_pipe.sv
// rtl/fp2i_pipe.sv - three-stage IEEE-754 single to int32 converter, truncating, saturating
module fp2i_pipe #(
    parameter logic [31:0] NAN_VALUE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_num,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_num,
    output logic        out_invalid,
    output logic        out_inexact
);

    logic        v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic        s1_sign_q, s1_sign_d, s1_nan_q, s1_nan_d, s1_inf_q, s1_inf_d;
    logic        s1_small_q, s1_small_d, s1_over_q, s1_over_d;
    logic [7:0]  s1_exp_q, s1_exp_d;
    logic [22:0] s1_frac_q, s1_frac_d;
    logic        s2_sign_q, s2_sign_d, s2_nan_q, s2_nan_d, s2_inf_q, s2_inf_d;
    logic        s2_over_q, s2_over_d, s2_inexact_q, s2_inexact_d;
    logic [31:0] s2_mag_q, s2_mag_d;
    logic [31:0] out_num_q, out_num_d;
    logic        out_invalid_q, out_invalid_d, out_inexact_q, out_inexact_d;

    logic        load3, load2;
    logic [7:0]  in_exp;
    logic [22:0] in_frac;
    logic [31:0] mant, mask;
    logic [7:0]  sh;

    // A stage may load whenever it is empty or its occupant moves on this cycle.
    assign load3    = ~v3_q | out_ready;
    assign load2    = ~v2_q | load3;
    assign in_ready = ~v1_q | load2;

    assign in_exp  = in_num[30:23];
    assign in_frac = in_num[22:0];

    always_comb begin
        v1_d       = in_ready ? in_valid : v1_q;
        s1_sign_d  = s1_sign_q;
        s1_exp_d   = s1_exp_q;
        s1_frac_d  = s1_frac_q;
        s1_nan_d   = s1_nan_q;
        s1_inf_d   = s1_inf_q;
        s1_small_d = s1_small_q;
        s1_over_d  = s1_over_q;
        if (in_ready && in_valid) begin
            s1_sign_d  = in_num[31];
            s1_exp_d   = in_exp;
            s1_frac_d  = in_frac;
            s1_nan_d   = (in_exp == 8'hFF) && (in_frac != 23'd0);
            s1_inf_d   = (in_exp == 8'hFF) && (in_frac == 23'd0);
            s1_small_d = in_exp < 8'd127;
            // -2^31 is the one value with exponent 158 that still fits.
            s1_over_d  = (in_exp >= 8'd158) && (in_num != 32'hCF00_0000);
        end
    end

    always_comb begin
        mant = {8'd0, (s1_exp_q != 8'd0), s1_frac_q};
        sh   = 8'd0;
        mask = 32'd0;
        v2_d         = load2 ? v1_q : v2_q;
        s2_sign_d    = s2_sign_q;
        s2_nan_d     = s2_nan_q;
        s2_inf_d     = s2_inf_q;
        s2_over_d    = s2_over_q;
        s2_mag_d     = s2_mag_q;
        s2_inexact_d = s2_inexact_q;
        if (load2 && v1_q) begin
            s2_sign_d = s1_sign_q;
            s2_nan_d  = s1_nan_q;
            s2_inf_d  = s1_inf_q;
            s2_over_d = s1_over_q;
            if (s1_small_q) begin
                s2_mag_d     = 32'd0;
                s2_inexact_d = (s1_exp_q != 8'd0) || (s1_frac_q != 23'd0);
            end else if (s1_exp_q >= 8'd150) begin
                sh           = s1_exp_q - 8'd150;
                s2_mag_d     = mant << sh;
                s2_inexact_d = 1'b0;
            end else begin
                sh           = 8'd150 - s1_exp_q;
                mask         = (32'd1 << sh) - 32'd1;
                s2_mag_d     = mant >> sh;
                s2_inexact_d = |(mant & mask);
            end
        end
    end

    always_comb begin
        v3_d          = load3 ? v2_q : v3_q;
        out_num_d     = out_num_q;
        out_invalid_d = out_invalid_q;
        out_inexact_d = out_inexact_q;
        if (load3 && v2_q) begin
            if (s2_nan_q) begin
                out_num_d     = NAN_VALUE;
                out_invalid_d = 1'b1;
                out_inexact_d = 1'b0;
            end else if (s2_inf_q || s2_over_q) begin
                out_num_d     = s2_sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
                out_invalid_d = 1'b1;
                out_inexact_d = 1'b0;
            end else begin
                out_num_d     = s2_sign_q ? (~s2_mag_q + 32'd1) : s2_mag_q;
                out_invalid_d = 1'b0;
                out_inexact_d = s2_inexact_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q          <= 1'b0;
            v2_q          <= 1'b0;
            v3_q          <= 1'b0;
            s1_sign_q     <= 1'b0;
            s1_exp_q      <= 8'd0;
            s1_frac_q     <= 23'd0;
            s1_nan_q      <= 1'b0;
            s1_inf_q      <= 1'b0;
            s1_small_q    <= 1'b0;
            s1_over_q     <= 1'b0;
            s2_sign_q     <= 1'b0;
            s2_nan_q      <= 1'b0;
            s2_inf_q      <= 1'b0;
            s2_over_q     <= 1'b0;
            s2_mag_q      <= 32'd0;
            s2_inexact_q  <= 1'b0;
            out_num_q     <= 32'd0;
            out_invalid_q <= 1'b0;
            out_inexact_q <= 1'b0;
        end else begin
            v1_q          <= v1_d;
            v2_q          <= v2_d;
            v3_q          <= v3_d;
            s1_sign_q     <= s1_sign_d;
            s1_exp_q      <= s1_exp_d;
            s1_frac_q     <= s1_frac_d;
            s1_nan_q      <= s1_nan_d;
            s1_inf_q      <= s1_inf_d;
            s1_small_q    <= s1_small_d;
            s1_over_q     <= s1_over_d;
            s2_sign_q     <= s2_sign_d;
            s2_nan_q      <= s2_nan_d;
            s2_inf_q      <= s2_inf_d;
            s2_over_q     <= s2_over_d;
            s2_mag_q      <= s2_mag_d;
            s2_inexact_q  <= s2_inexact_d;
            out_num_q     <= out_num_d;
            out_invalid_q <= out_invalid_d;
            out_inexact_q <= out_inexact_d;
        end
    end

    assign out_valid   = v3_q;
    assign out_num     = out_num_q;
    assign out_invalid = out_invalid_q;
    assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_fp2i_pipe.sv
// tb/tb_fp2i_pipe.sv - scoreboard bench for fp2i_pipe against a real-arithmetic reference
module tb_fp2i_pipe;

    localparam logic [31:0] NANV = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_num = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_num;
    logic        out_invalid;
    logic        out_inexact;

    fp2i_pipe #(.NAN_VALUE(NANV)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num),
        .out_valid(out_valid), .out_ready(out_ready), .out_num(out_num),
        .out_invalid(out_invalid), .out_inexact(out_inexact)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [33:0] res;
        int          stamp;
    } exp_t;

    exp_t        sb[$];
    logic [33:0] dir_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    bit          lat_mode = 0;
    bit          prev_stall = 0;
    logic [33:0] prev_out;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got inv=%0b inx=%0b num=%h, want inv=%0b inx=%0b num=%h",
                     name, act[33], act[32], act[31:0], exp[33], exp[32], exp[31:0]);
        end
    endtask

    // Reference: value of the float as a real, truncated toward zero, saturated at int32 limits.
    function automatic logic [33:0] ref_conv(input logic [31:0] x);
        logic [7:0]  e;
        logic [22:0] f;
        real         mag, v;
        int          p, t;
        e = x[30:23];
        f = x[22:0];
        if (e == 8'hFF)
            return (f != 0) ? {2'b10, NANV} : {2'b10, (x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF)};
        mag = (e == 0) ? real'(f) : real'(f) + 8388608.0;
        p   = (e == 0) ? -149 : int'(e) - 150;
        for (int i = 0; i < p; i++) mag = mag * 2.0;
        for (int i = 0; i < -p; i++) mag = mag / 2.0;
        v = x[31] ? -mag : mag;
        if (v >= 2147483648.0) return {2'b10, 32'h7FFF_FFFF};
        if (v < -2147483648.0) return {2'b10, 32'h8000_0000};
        t = $rtoi(v);
        return {1'b0, (real'(t) != v), t};
    endfunction

    always @(negedge rst_n) begin
        sb.delete();
        dir_q.delete();
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (in_valid && in_ready) begin
                exp_t e;
                e.res   = (dir_q.size() > 0) ? dir_q.pop_front() : ref_conv(in_num);
                e.stamp = cyc;
                sb.push_back(e);
            end
            if (prev_stall) begin
                chk("stall_hold", {out_invalid, out_inexact, out_num}, prev_out);
                tests++;
                if (!out_valid) begin
                    fails++;
                    $display("FAIL stall_valid: out_valid dropped while stalled, got 0 want 1");
                end
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: got num=%h with empty scoreboard, want none", out_num);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", {out_invalid, out_inexact, out_num}, e.res);
                    if (lat_mode) begin
                        tests++;
                        if (cyc - e.stamp != 3) begin
                            fails++;
                            $display("FAIL latency: got %0d cycles want 3", cyc - e.stamp);
                        end
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_invalid, out_inexact, out_num};
        end
    end

    function automatic logic [31:0] rand_operand();
        logic [31:0] specials [8];
        specials = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                     32'h7FC0_0000, 32'hCF00_0000, 32'h4F00_0000, 32'h0000_0001};
        if ($urandom_range(7) == 0) return specials[$urandom_range(7)];
        return {1'($urandom), 8'($urandom_range(165, 110)), 23'($urandom)};
    endfunction

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s: %0d results outstanding, want 0", name, sb.size());
        end
    endtask

    logic [31:0] dir_in  [14];
    logic [33:0] dir_exp [14];

    initial begin
        int sent, cycles, acc;
        bit stale;
        dir_in  = '{32'h4070_0000, 32'hC020_0000, 32'h4B00_0001, 32'h4E80_0000, 32'h3F00_0000,
                    32'h8000_0000, 32'h4F00_0000, 32'hCF00_0000, 32'hCF00_0001, 32'h7FC0_0000,
                    32'h7F80_0000, 32'hFF80_0000, 32'h0000_0001, 32'h4EFF_FFFF};
        dir_exp = '{{2'b01, 32'h0000_0003}, {2'b01, 32'hFFFF_FFFE}, {2'b00, 32'h0080_0001},
                    {2'b00, 32'h4000_0000}, {2'b01, 32'h0000_0000}, {2'b00, 32'h0000_0000},
                    {2'b10, 32'h7FFF_FFFF}, {2'b00, 32'h8000_0000}, {2'b10, 32'h8000_0000},
                    {2'b10, NANV},          {2'b10, 32'h7FFF_FFFF}, {2'b10, 32'h8000_0000},
                    {2'b01, 32'h0000_0000}, {2'b00, 32'h7FFF_FF80}};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_out", {out_invalid, out_inexact, out_num}, 34'd0);
        chk("reset_valid", {33'd0, out_valid}, 34'd0);
        chk("reset_in_ready", {33'd0, in_ready}, 34'd1);

        lat_mode = 1;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            dir_q.push_back(dir_exp[i]);
            in_valid = 1'b1;
            in_num   = dir_in[i];
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain("drain_directed");
        lat_mode = 0;

        sent = 0;
        cycles = 0;
        in_num = rand_operand();
        while (sent < 100 && cycles < 5000) begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(2) != 0);
            in_valid  = ($urandom_range(3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) begin
                sent++;
                @(posedge clk);
                #1 in_num = rand_operand();
                in_valid = 1'b0;
                out_ready = ($urandom_range(2) != 0);
            end
            cycles++;
        end
        tests++;
        if (sent < 100) begin
            fails++;
            $display("FAIL random_send: got %0d accepted want 100", sent);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        out_ready = 1'b1;
        drain("drain_random");

        out_ready = 1'b0;
        acc = 0;
        cycles = 0;
        while (acc < 3 && cycles < 20) begin
            @(posedge clk);
            #1 in_valid = 1'b1;
            in_num = rand_operand();
            @(negedge clk);
            if (in_ready) acc++;
            cycles++;
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("full_in_ready", {33'd0, in_ready}, 34'd0);
        chk("full_out_valid", {33'd0, out_valid}, 34'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_valid", {33'd0, out_valid}, 34'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", {33'd0, in_ready}, 34'd1);
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale = 1;
        end
        chk("no_stale_output", {33'd0, stale}, 34'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
